// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the latency counter width.
package dmem_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } dsize_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for one 32-bit word: store merge, load extract with
// sign/zero extension, and misalignment detection. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [0:31] i_oldWord,
  input  logic [0:31] i_wdata,
  input  logic [0:1]  i_offset,
  input  logic [0:1]  i_dsize,
  input  logic        i_dsign,
  output logic [0:3]  o_wmask,
  output logic [0:31] o_mergedWord,
  output logic [0:31] o_loadData,
  output logic        o_misalign
);

  logic        w_isByte;
  logic        w_isHalf;
  logic        w_isWord;
  logic        w_fill;
  logic [0:7]  w_byte;
  logic [0:15] w_half;
  logic [0:31] w_storeLanes;

  // Size code 11 behaves as a word access.
  assign w_isWord = i_dsize[0];
  assign w_isHalf = (i_dsize == SZ_HALF);
  assign w_isByte = (i_dsize == SZ_BYTE);

  assign o_misalign = (w_isHalf && i_offset[1]) || (w_isWord && (i_offset != 2'b00));

  assign w_byte = i_oldWord[{i_offset, 3'b000} +: 8];
  assign w_half = i_oldWord[{i_offset[0], 4'b0000} +: 16];
  assign w_fill = i_dsign & (w_isByte ? w_byte[0] : w_half[0]);

  // Replicate right-justified store data into every lane it could land in.
  assign w_storeLanes = w_isWord ? i_wdata :
                        w_isHalf ? {i_wdata[16:31], i_wdata[16:31]} :
                                   {4{i_wdata[24:31]}};

  always_comb begin
    o_loadData = '0;
    if (!o_misalign) begin
      if (w_isWord)
        o_loadData = i_oldWord;
      else if (w_isHalf)
        o_loadData = {{16{w_fill}}, w_half};
      else
        o_loadData = {{24{w_fill}}, w_byte};
    end
  end

  always_comb begin
    o_wmask      = '0;
    o_mergedWord = i_oldWord;
    for (int i = 0; i < 4; i++) begin
      o_wmask[i] = !o_misalign &&
                   (w_isWord ||
                    (w_isHalf && (i_offset[0] == 1'(i >> 1))) ||
                    (w_isByte && (i_offset == 2'(i))));
      if (o_wmask[i])
        o_mergedWord[8*i +: 8] = w_storeLanes[8*i +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: holds one load/store for LATENCY
// cycles under stall, then commits and pulses ready for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [0:31] i_addr,
  input  logic [0:31] i_wdata,
  input  logic        i_we,
  input  logic [0:1]  i_dsize,
  input  logic        i_dsign,
  output logic [0:31] o_rdata,
  output logic        o_ready,
  output logic        o_stall,
  output logic        o_err
);

  localparam int IDX_W = ADDR_BITS - 2;
  localparam int DEPTH = 1 << IDX_W;

  state_e             r_state;
  state_e             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [0:31]        r_addr;
  logic [0:31]        r_wdata;
  logic               r_we;
  logic [0:1]         r_dsize;
  logic               r_dsign;
  logic [0:31]        r_rdata;
  logic               r_ready;
  logic               r_err;
  logic [0:31]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_commit;
  logic [0:31]        w_addr;
  logic [0:31]        w_wdata;
  logic               w_we;
  logic [0:1]         w_dsize;
  logic               w_dsign;
  logic [IDX_W-1:0]   w_wordIdx;
  logic [0:31]        w_oldWord;
  logic [0:3]         w_wmask;
  logic [0:31]        w_mergedWord;
  logic [0:31]        w_loadData;
  logic               w_misalign;
  logic               w_unusedAddr;

  assign w_accept = (r_state == IDLE) && i_req;
  assign w_commit = (w_accept && (LATENCY == 1)) ||
                    ((r_state == WAIT) && (r_cnt == CNT_W'(1)));

  // With LATENCY=1 the commit edge is also the accept edge, so use live inputs.
  assign w_addr  = (r_state == IDLE) ? i_addr  : r_addr;
  assign w_wdata = (r_state == IDLE) ? i_wdata : r_wdata;
  assign w_we    = (r_state == IDLE) ? i_we    : r_we;
  assign w_dsize = (r_state == IDLE) ? i_dsize : r_dsize;
  assign w_dsign = (r_state == IDLE) ? i_dsign : r_dsign;

  assign w_wordIdx    = w_addr[32-ADDR_BITS:29];
  assign w_unusedAddr = ^w_addr[0:31-ADDR_BITS];
  assign w_oldWord    = r_mem[w_wordIdx];

  dmem_lane_align u_align (
    .i_oldWord    (w_oldWord),
    .i_wdata      (w_wdata),
    .i_offset     (w_addr[30:31]),
    .i_dsize      (w_dsize),
    .i_dsign      (w_dsign),
    .o_wmask      (w_wmask),
    .o_mergedWord (w_mergedWord),
    .o_loadData   (w_loadData),
    .o_misalign   (w_misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // DONE always returns to IDLE, so a request still held from the same
  // instruction is not accepted a second time.
  always_comb begin
    w_nextState = r_state;
    o_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        o_stall = i_req;
        if (i_req)
          w_nextState = (LATENCY > 1) ? WAIT : DONE;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (r_cnt == CNT_W'(1))
          w_nextState = DONE;
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_dsize <= '0;
      r_dsign <= 1'b0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_commit;
      if (w_accept) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_we    <= i_we;
        r_dsize <= i_dsize;
        r_dsign <= i_dsign;
        r_cnt   <= CNT_W'(LATENCY - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit) begin
        r_rdata <= w_we ? '0 : w_loadData;
        r_err   <= w_misalign;
      end
    end
  end

  // Array is not reset; a reset edge discards any pending store.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && (|w_wmask) && !reset)
      r_mem[w_wordIdx] <= w_mergedWord;
  end

  assign o_rdata = r_rdata;
  assign o_ready = r_ready;
  assign o_err   = r_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the MEM-stage memory interface. Accepts one load/store request at a time and holds it for a configurable latency while asserting stall to freeze the pipeline. Performs big-endian byte/half/word access with sign or zero extension on loads. Returns read data with a one-cycle ready pulse, and flags misaligned accesses.

Parameters:
ADDR_BITS, 12, byte-address bits decoded; array holds 2^(ADDR_BITS-2) 32-bit words; upper address bits are ignored, so addresses wrap.
LATENCY, 2, cycles from request acceptance to completion; legal range 1..15.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  1  access request; driven by (load | store) of the instruction in MEM
addr  input  [0:31]  byte address; bit 0 is MSB
wdata  input  [0:31]  store data, right-justified for byte/half
we  input  1  store request; must be driven by the ungated write enable, not the stall-gated one
dsize  input  [0:1]  access size: 00 byte, 01 half, 10 word, 11 treated as word
dsign  input  1  1 = sign-extend loads, 0 = zero-extend
rdata  output  [0:31]  load result; valid while ready=1, held afterwards
ready  output  1  one-cycle completion pulse
stall  output  1  pipeline freeze while a request is outstanding
err  output  1  misaligned access flag; valid with ready

Behaviour:
- Reset: clk and reset as decided (reset asynchronous, active-high; clock clk).
  - Reset values: state=IDLE, rdata=0, ready=0, err=0, counter=0, stall=0.
  - Array contents are not reset.
- States:
  - IDLE: no request outstanding.
  - WAIT: request latched, counting down.
  - DONE: completion cycle.
- IDLE:
  - stall = req (combinational).
  - On an edge with req=1, latch addr/wdata/we/dsize/dsign and load counter=LATENCY-1.
  - Next state is WAIT if LATENCY>1, else DONE.
- WAIT:
  - stall=1; counter decrements each edge.
  - At the edge where counter==1, go to DONE.
- DONE:
  - ready=1, stall=0; pipeline advances at the end of this cycle.
  - Next state is IDLE unconditionally.
  - req is ignored during DONE, so a repeated request from the same instruction is never re-accepted.
- Timing: request presented in cycle T gives stall high for cycles T..T+LATENCY-1 and ready in cycle T+LATENCY. Back-to-back requests therefore occupy LATENCY+1 cycles each.
- Commit: the store write and the rdata/err registers all update on the edge entering DONE. Exactly one array write per accepted store.
- Endianness: big-endian. Byte offset 0 maps to bits [0:7] of the word, offset 3 to bits [24:31].
- Loads:
  - Byte: selected lane goes to rdata[24:31]; bits [0:23] are filled with the sign (if dsign) or zeros.
  - Half: offset 0 or 2 goes to rdata[16:31]; upper bits filled the same way.
  - Word: loaded unmodified.
- Stores:
  - Byte: wdata[24:31] is written to the addressed lane only.
  - Half: wdata[16:31] is written to the addressed half only.
  - Word: the full word is written.
  - Other lanes are preserved.
- Misalignment:
  - A half with addr[31]=1, or a word with addr[30:31]!=0, is misaligned.
  - Result: no array write, rdata=0, err=1 for the ready cycle. Otherwise err=0.
- A store leaves rdata at 0; ready still pulses.
- Reset mid-request: return to IDLE immediately; an uncommitted store is discarded; ready is not issued.
- ready and err are registered. Only stall is combinational, from state and req.

Decomposition:
- Package dmem_pkg:
  - dsize encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state encoding: IDLE, WAIT, DONE.
  - Counter width constant: 4.
- Sub-module dmem_lane_align (combinational):
  - Store path: builds write-lane mask and merged word from old word, wdata, offset and size.
  - Load path: extracts and extends load data.
  - Misalign detect.
  - Unit-testable in isolation.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF at 0x10, then load word at 0x10 with dsign=0 -> stall high 2 cycles, ready in the 3rd; rdata=0xDEADBEEF, err=0.
- Load byte at 0x11, dsign=1 -> rdata=0xFFFFFFAD. Repeat with dsign=0 -> rdata=0x000000AD.
- Load half at 0x12, dsign=1 -> 0xFFFFBEEF. Store byte 0x5A at 0x13, then load word at 0x10 -> 0xDEADBE5A.
- Store word at 0x11 -> err=1 with ready, rdata=0; a following word load at 0x10 still returns 0xDEADBE5A.
- Store 0x12345678 at 0x20, assert reset in the WAIT cycle -> outputs 0, state IDLE, no ready. Reload 0x20 -> prior contents unchanged.
- LATENCY=1, req held high for 4 consecutive requests -> stall/ready alternate 1/0, 0/1 each cycle. Address 0x1010 with ADDR_BITS=12 aliases 0x010.
